// File: rtl/fifo_channel_if.sv
// Producer/consumer bus of the FIFO channel: push side, pop side and status.
interface fifo_channel_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LOG_DEPTH  = 6
);
    logic                  push_en;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_enable;
    logic                  pop_valid;
    logic [DATA_WIDTH-1:0] pop_data;
    logic [LOG_DEPTH-1:0]  pop_dw;
    logic                  error;

    // Client side: drives push/pop requests, observes data and status.
    modport master (
        output push_en,
        output push_data,
        output pop_enable,
        input  pop_valid,
        input  pop_data,
        input  pop_dw,
        input  error
    );

    // FIFO side: accepts requests, returns data and status.
    modport slave (
        input  push_en,
        input  push_data,
        input  pop_enable,
        output pop_valid,
        output pop_data,
        output pop_dw,
        output error
    );
endinterface

// File: rtl/fifo_channel.sv
// Single-clock circular FIFO with registered read data, live fill level and
// a sticky overflow/underflow flag. Capacity is 2^LOG_DEPTH - 1 words.
module fifo_channel #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LOG_DEPTH  = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    fifo_channel_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << LOG_DEPTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [LOG_DEPTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LOG_DEPTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LOG_DEPTH-1:0]  count_q, count_d;
    logic                  pop_valid_q, pop_valid_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  error_q, error_d;

    logic                  push_ok;
    logic                  pop_ok;

    // Accept decisions use only the current count: no bypass between push and pop.
    always_comb begin
        push_ok = bus.push_en    && (count_q != '1);
        pop_ok  = bus.pop_enable && (count_q != '0);
    end

    // Next-state for pointers, count, read data and sticky error.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        error_d     = error_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + LOG_DEPTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d    = rd_ptr_q + LOG_DEPTH'(1);
            pop_valid_d = 1'b1;
            pop_data_d  = mem[rd_ptr_q];
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LOG_DEPTH'(1);
            2'b01:   count_d = count_q - LOG_DEPTH'(1);
            default: count_d = count_q;
        endcase

        if ((bus.push_en && !push_ok) || (bus.pop_enable && !pop_ok)) begin
            error_d = 1'b1;
        end
    end

    // Control and output registers; cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
            error_q     <= error_d;
        end
    end

    // Storage array; contents survive reset and are only written on accepted pushes.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= bus.push_data;
        end
    end

    assign bus.pop_valid = pop_valid_q;
    assign bus.pop_data  = pop_data_q;
    assign bus.pop_dw    = count_q;
    assign bus.error     = error_q;

endmodule

// File: tb/tb_fifo_channel.sv
// Directed self-checking bench for fifo_channel (DATA_WIDTH=64, LOG_DEPTH=6).
module tb_fifo_channel;
    localparam int unsigned DW = 64;
    localparam int unsigned LD = 6;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    fifo_channel_if #(.DATA_WIDTH(DW), .LOG_DEPTH(LD)) bus ();

    fifo_channel #(.DATA_WIDTH(DW), .LOG_DEPTH(LD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.push_en    = 1'b0;
        bus.push_data  = '0;
        bus.pop_enable = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();

        // ---- Reset ----
        tick();
        tick();
        chk("rst_hold_valid", 64'(bus.pop_valid), 64'd0);
        chk("rst_hold_data",  64'(bus.pop_data),  64'd0);
        chk("rst_hold_dw",    64'(bus.pop_dw),    64'd0);
        chk("rst_hold_err",   64'(bus.error),     64'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_rel_dw",  64'(bus.pop_dw), 64'd0);
        chk("rst_rel_err", 64'(bus.error),  64'd0);

        for (int i = 0; i < 3; i++) begin
            bus.push_en   = 1'b1;
            bus.push_data = 64'hA1 + 64'(i);
            tick();
            chk("rst_push_dw", 64'(bus.pop_dw), 64'(i + 1));
        end
        bus.push_data = 64'hA4;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_dw",    64'(bus.pop_dw),    64'd0);
        chk("rst_mid_valid", 64'(bus.pop_valid), 64'd0);
        chk("rst_mid_err",   64'(bus.error),     64'd0);
        idle_inputs();
        tick();
        reset_n = 1'b1;
        tick();
        bus.pop_enable = 1'b1;
        tick();
        chk("rst_discard_valid", 64'(bus.pop_valid), 64'd0);
        chk("rst_discard_err",   64'(bus.error),     64'd1);
        chk("rst_discard_dw",    64'(bus.pop_dw),    64'd0);

        // ---- Ordering ----
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.push_en   = 1'b1;
            bus.push_data = 64'h10 + 64'(i);
            tick();
        end
        bus.push_en = 1'b0;
        chk("ord_dw4", 64'(bus.pop_dw), 64'd4);
        chk("ord_pre_valid", 64'(bus.pop_valid), 64'd0);
        bus.pop_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ord_valid", 64'(bus.pop_valid), 64'd1);
            chk("ord_data",  64'(bus.pop_data),  64'h10 + 64'(i));
            chk("ord_dw",    64'(bus.pop_dw),    64'(3 - i));
        end
        bus.pop_enable = 1'b0;
        tick();
        chk("ord_post_valid", 64'(bus.pop_valid), 64'd0);
        chk("ord_hold_data",  64'(bus.pop_data),  64'h13);
        chk("ord_err",        64'(bus.error),     64'd0);

        // ---- Full / overflow ----
        do_reset();
        for (int i = 0; i < 63; i++) begin
            bus.push_en   = 1'b1;
            bus.push_data = 64'h100 + 64'(i);
            tick();
        end
        chk("full_dw63", 64'(bus.pop_dw), 64'd63);
        chk("full_err0", 64'(bus.error),  64'd0);
        bus.push_data = 64'hDEAD;
        tick();
        bus.push_en = 1'b0;
        chk("ovf_err", 64'(bus.error),  64'd1);
        chk("ovf_dw",  64'(bus.pop_dw), 64'd63);
        bus.pop_enable = 1'b1;
        for (int i = 0; i < 63; i++) begin
            tick();
            chk("full_pop_valid", 64'(bus.pop_valid), 64'd1);
            chk("full_pop_data",  64'(bus.pop_data),  64'h100 + 64'(i));
        end
        bus.pop_enable = 1'b0;
        tick();
        chk("full_end_valid", 64'(bus.pop_valid), 64'd0);
        chk("full_end_dw",    64'(bus.pop_dw),    64'd0);
        chk("full_end_data",  64'(bus.pop_data),  64'h13E);

        // ---- Underflow ----
        do_reset();
        bus.pop_enable = 1'b1;
        tick();
        bus.pop_enable = 1'b0;
        chk("udf_valid", 64'(bus.pop_valid), 64'd0);
        chk("udf_err",   64'(bus.error),     64'd1);
        chk("udf_dw",    64'(bus.pop_dw),    64'd0);
        bus.push_en   = 1'b1;
        bus.push_data = 64'h55;
        tick();
        bus.push_en    = 1'b0;
        bus.pop_enable = 1'b1;
        tick();
        bus.pop_enable = 1'b0;
        chk("udf_pop_valid", 64'(bus.pop_valid), 64'd1);
        chk("udf_pop_data",  64'(bus.pop_data),  64'h55);
        chk("udf_err_sticky", 64'(bus.error),    64'd1);

        // ---- Simultaneous push and pop at count 2 ----
        do_reset();
        bus.push_en = 1'b1;
        bus.push_data = 64'h21;
        tick();
        bus.push_data = 64'h22;
        tick();
        bus.push_data  = 64'h23;
        bus.pop_enable = 1'b1;
        tick();
        bus.push_en = 1'b0;
        chk("sim_dw",    64'(bus.pop_dw),    64'd2);
        chk("sim_valid", 64'(bus.pop_valid), 64'd1);
        chk("sim_data",  64'(bus.pop_data),  64'h21);
        tick();
        chk("sim_data2", 64'(bus.pop_data), 64'h22);
        chk("sim_dw1",   64'(bus.pop_dw),   64'd1);
        tick();
        bus.pop_enable = 1'b0;
        chk("sim_data3", 64'(bus.pop_data), 64'h23);
        chk("sim_dw0",   64'(bus.pop_dw),   64'd0);
        chk("sim_err",   64'(bus.error),    64'd0);

        // ---- Wrap-around streaming ----
        do_reset();
        bus.push_en   = 1'b1;
        bus.push_data = 64'h1000;
        tick();
        chk("wrap_first_dw", 64'(bus.pop_dw), 64'd1);
        bus.pop_enable = 1'b1;
        for (int i = 1; i < 200; i++) begin
            bus.push_data = 64'h1000 + 64'(i);
            tick();
            chk("wrap_valid", 64'(bus.pop_valid), 64'd1);
            chk("wrap_data",  64'(bus.pop_data),  64'h1000 + 64'(i - 1));
            chk("wrap_dw",    64'(bus.pop_dw),    64'd1);
        end
        bus.push_en = 1'b0;
        tick();
        bus.pop_enable = 1'b0;
        chk("wrap_last_data", 64'(bus.pop_data), 64'h1000 + 64'd199);
        chk("wrap_last_dw",   64'(bus.pop_dw),   64'd0);
        chk("wrap_err",       64'(bus.error),    64'd0);
        tick();
        chk("wrap_idle_valid", 64'(bus.pop_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_channel.md
# fifo_channel

Single-clock, first-in first-out buffer with registered read data, a live fill-level output and a sticky error flag. It decouples a producer that pushes one word per cycle from a consumer that pops in bursts, e.g. the NIC-to-CPU write batching path, which pops a batch once enough words are buffered.

## Interface

**Parameters**
- `DATA_WIDTH`, default 64: width of each stored word.
- `LOG_DEPTH`, default 6: log2 of the storage array size. Usable capacity is 2^LOG_DEPTH − 1 words.

**Ports**
- `clk`, input, 1: the only clock; all logic is rising-edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `push_en`, input, 1: write `push_data` this cycle.
- `push_data`, input, DATA_WIDTH: word to store.
- `pop_enable`, input, 1: request the oldest word.
- `pop_valid`, output, 1: `pop_data` carries a popped word this cycle.
- `pop_data`, output, DATA_WIDTH: registered read data.
- `pop_dw`, output, LOG_DEPTH: number of words currently stored.
- `error`, output, 1: sticky overflow/underflow flag.

## Operation

- Storage is a circular array of 2^LOG_DEPTH entries with LOG_DEPTH-bit write and read pointers. Pointers wrap naturally modulo 2^LOG_DEPTH.
- `count` is a LOG_DEPTH-bit register. It is full at 2^LOG_DEPTH − 1 and empty at 0. `pop_dw` = `count`.
- **Push accepted** when `push_en` = 1 and `count` ≠ full: write at the write pointer, then increment the write pointer.
- **Push when full:** the data is dropped, the pointer and count are unchanged, and `error` is set. This holds even if a pop is accepted in the same cycle.
- **Pop accepted** when `pop_enable` = 1 and `count` ≠ 0: read at the read pointer into `pop_data`, increment the read pointer, and set `pop_valid` = 1 on the next cycle.
- **Pop when empty:** no data, `pop_valid` stays 0, and `error` is set. This holds even if a push is accepted in the same cycle; there is no bypass or fall-through.
- **Simultaneous accepted push and pop:** both take effect and `count` is unchanged.
- Otherwise `count` changes by +1 for an accepted push and −1 for an accepted pop.
- `pop_data` holds its last popped value when `pop_valid` = 0.
- `error` stays 1 until reset and does not block further operation.
- Storage contents are not reset. Only the pointers, `count` and the outputs are reset.

## Timing

- **Reset:** asserting `reset_n` = 0 at any time, including mid-burst, immediately clears all of the following. All stored words are discarded.
  - `pop_valid` = 0
  - `pop_data` = 0
  - `pop_dw` = 0
  - `error` = 0
  - both pointers = 0
- **Push-to-count latency:** 1 cycle. A push at edge N is reflected in `pop_dw` after edge N.
- **Push-to-pop:** the earliest accepted pop of a pushed word is the cycle after the push edge. Data then appears the cycle after that.
- **Pop latency:** 1 cycle. `pop_enable` sampled at edge N gives `pop_valid` and `pop_data` after edge N, valid for exactly one cycle per accepted pop.
- **Back-to-back pops:** accepted every cycle, giving one `pop_valid` per cycle.
- **Status outputs:** `pop_dw` and `error` are registered outputs.
- **Throughput:** one push and one pop per cycle.

## Test plan

- **Reset:** hold `reset_n` low, then release. Expect all outputs 0. Push 0xA1, 0xA2, 0xA3 on consecutive cycles. Expect `pop_dw` to read 1, 2, 3. Then pulse `reset_n` low mid-sequence; expect `pop_dw` = 0 immediately and no further `pop_valid`.
- **Ordering:** push 4 words 0x10–0x13, then assert `pop_enable` for 4 consecutive cycles. Expect `pop_valid` high for 4 cycles, each starting one cycle after its pop, with data 0x10, 0x11, 0x12, 0x13. Expect `pop_dw` to fall 4→0 and `error` to remain 0.
- **Full/overflow (LOG_DEPTH = 6):**
  - Push 63 words, then expect `pop_dw` = 63.
  - Push a 64th word, then expect `error` = 1 and `pop_dw` = 63.
  - Pop 63 words, then expect the first 63 values in order, with the 64th word absent.
- **Underflow:** pop while empty. Expect no `pop_valid` and `error` = 1. Then push and pop one word; expect correct data and `error` still 1.
- **Simultaneous push and pop at `count` = 2:** `pop_dw` stays 2, the popped word is the oldest, and the new word is popped last.
- **Wrap-around:** stream 200 words with a push and a pop every cycle after an initial push. Expect every word out in order, `pop_dw` = 1 steady, and `error` = 0.
